// File: rtl/free_ptr_pool.sv
// ============================================================================
// Module   : free_ptr_pool
// Purpose  : FIFO-ordered pool of free buffer pointers. The pool optionally
//            self-loads pointers 0..NUM_PTRS-1 after reset. It hands pointers
//            out on a valid/ready allocation port and takes them back on a
//            return port. An allocated-map rejects returns of pointers that
//            are already free and returns of pointers out of range.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            alloc_valid/ready  - allocation handshake, alloc_ptr = pointer
//            free_valid/ptr     - pointer return, free_ready = accepting
//            free_count         - pointers currently held in the pool
//            low_wm             - free_count below LOW_WM (forced high in INIT)
//            init_done          - pool loaded and running
//            err_double_free    - pulse: rejected return of an already-free ptr
//            err_range          - pulse: rejected return with ptr >= NUM_PTRS
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module free_ptr_pool #(
   parameter int PTR_WIDTH = 10,
   parameter int NUM_PTRS  = 2**PTR_WIDTH,
   parameter int INIT_EN   = 1,
   parameter int LOW_WM    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 alloc_valid,
   input  logic                 alloc_ready,
   output logic [PTR_WIDTH-1:0] alloc_ptr,
   input  logic                 free_valid,
   input  logic [PTR_WIDTH-1:0] free_ptr,
   output logic                 free_ready,
   output logic [PTR_WIDTH:0]   free_count,
   output logic                 low_wm,
   output logic                 init_done,
   output logic                 err_double_free,
   output logic                 err_range
);

   localparam int                    CW         = PTR_WIDTH + 1;
   localparam logic [CW-1:0]         c_NUM      = CW'(NUM_PTRS);
   localparam logic [CW-1:0]         c_LOW_WM   = CW'(LOW_WM);
   localparam logic [PTR_WIDTH-1:0]  c_LAST     = PTR_WIDTH'(NUM_PTRS - 1);
   localparam logic [NUM_PTRS-1:0]   c_MAP_RST  = (INIT_EN != 0) ? '0 : '1;

   localparam logic [0:0] c_INIT = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   // Pointer storage: simple-dual-port RAM with a registered read port
   logic [PTR_WIDTH-1:0] mem [NUM_PTRS];

   logic [0:0]           state_q, state_d;
   logic [CW-1:0]        ld_cnt_q, ld_cnt_d;
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        ram_cnt_q, ram_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [PTR_WIDTH-1:0] rdata_q;
   logic [CW-1:0]        free_count_q, free_count_d;
   logic                 low_wm_q, low_wm_d;
   logic                 err_dbl_q, err_dbl_d;
   logic                 err_rng_q, err_rng_d;
   logic [NUM_PTRS-1:0]  map_q, map_d;

   logic                 w_run;
   logic                 w_alloc_fire;
   logic                 w_free_take;
   logic                 w_range_bad;
   logic                 w_free_accept;
   logic                 w_init_wr;
   logic                 w_we;
   logic [PTR_WIDTH-1:0] w_wdata;
   logic                 w_re;

   function automatic logic [PTR_WIDTH-1:0] f_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == c_LAST) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   assign w_run         = (state_q == c_RUN);
   // The read register may prefetch during INIT; nothing is offered until RUN
   assign alloc_valid   = out_valid_q & w_run;
   assign alloc_ptr     = rdata_q;
   assign w_alloc_fire  = alloc_valid & alloc_ready;

   assign w_free_take   = w_run & free_valid;
   assign w_range_bad   = ({1'b0, free_ptr} >= c_NUM);
   // A pointer may only come back if the map says it is out on loan
   assign w_free_accept = w_free_take & ~w_range_bad & map_q[free_ptr];

   assign w_init_wr     = (state_q == c_INIT) && (INIT_EN != 0);
   assign w_we          = w_init_wr | w_free_accept;
   assign w_wdata       = w_init_wr ? ld_cnt_q[PTR_WIDTH-1:0] : free_ptr;

   // Fetch the next head whenever the RAM holds something and the output slot
   // is empty or being consumed; this gives one allocation per cycle. The RAM
   // is never read at the address being written: reads need ram_cnt_q > 0.
   assign w_re          = (ram_cnt_q != '0) && (!out_valid_q || w_alloc_fire);

   always_comb begin
      state_d      = state_q;
      ld_cnt_d     = ld_cnt_q;
      wr_ptr_d     = w_we ? f_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = w_re ? f_inc(rd_ptr_q) : rd_ptr_q;
      ram_cnt_d    = ram_cnt_q + CW'(w_we) - CW'(w_re);
      free_count_d = free_count_q + CW'(w_we) - CW'(w_alloc_fire);
      out_valid_d  = w_re ? 1'b1 : (w_alloc_fire ? 1'b0 : out_valid_q);
      err_rng_d    = w_free_take & w_range_bad;
      err_dbl_d    = w_free_take & ~w_range_bad & ~map_q[free_ptr];

      map_d = map_q;
      if (w_alloc_fire) map_d[alloc_ptr] = 1'b1;
      if (w_free_accept) map_d[free_ptr] = 1'b0;

      if (state_q == c_INIT) begin
         if (INIT_EN == 0) begin
            state_d = c_RUN;
         end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
            if (ld_cnt_q == c_NUM - CW'(1)) state_d = c_RUN;
         end
      end

      // Aligned with free_count: both take their new value on the same edge
      low_wm_d = (state_d == c_INIT) || (free_count_d < c_LOW_WM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= c_INIT;
         ld_cnt_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ram_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         free_count_q <= '0;
         low_wm_q     <= 1'b1;
         err_dbl_q    <= 1'b0;
         err_rng_q    <= 1'b0;
         map_q        <= c_MAP_RST;
      end else begin
         state_q      <= state_d;
         ld_cnt_q     <= ld_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ram_cnt_q    <= ram_cnt_d;
         out_valid_q  <= out_valid_d;
         free_count_q <= free_count_d;
         low_wm_q     <= low_wm_d;
         err_dbl_q    <= err_dbl_d;
         err_rng_q    <= err_rng_d;
         map_q        <= map_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) mem[wr_ptr_q] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (w_re) begin
         rdata_q <= mem[rd_ptr_q];
      end
   end

   assign free_ready      = w_run;
   assign free_count      = free_count_q;
   assign low_wm          = low_wm_q;
   assign init_done       = w_run;
   assign err_double_free = err_dbl_q;
   assign err_range       = err_rng_q;

endmodule

`default_nettype wire

// File: tb/tb_free_ptr_pool.sv
// ============================================================================
// Module   : tb_free_ptr_pool
// Purpose  : Self-checking bench for free_ptr_pool (PTR_WIDTH=4, NUM_PTRS=12).
//            A queue-based model of the pool is compared against the DUT
//            every cycle, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_ptr_pool;

   localparam int PW  = 4;
   localparam int NUM = 12;
   localparam int LWM = 4;

   logic          clk;
   logic          rst;
   logic          alloc_valid;
   logic          alloc_ready;
   logic [PW-1:0] alloc_ptr;
   logic          free_valid;
   logic [PW-1:0] free_ptr;
   logic          free_ready;
   logic [PW:0]   free_count;
   logic          low_wm;
   logic          init_done;
   logic          err_double_free;
   logic          err_range;

   free_ptr_pool #(
      .PTR_WIDTH (PW),
      .NUM_PTRS  (NUM),
      .INIT_EN   (1),
      .LOW_WM    (LWM)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_valid     (alloc_valid),
      .alloc_ready     (alloc_ready),
      .alloc_ptr       (alloc_ptr),
      .free_valid      (free_valid),
      .free_ptr        (free_ptr),
      .free_ready      (free_ready),
      .free_count      (free_count),
      .low_wm          (low_wm),
      .init_done       (init_done),
      .err_double_free (err_double_free),
      .err_range       (err_range)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- model: pool as a queue of (pointer, first visible cycle)
   int m_qp[$];
   int m_qv[$];
   bit m_map[NUM];
   int m_cnt     = 0;
   int m_ld      = 0;
   bit m_run     = 0;
   bit m_errd    = 0;
   bit m_errr    = 0;
   bit m_rst     = 0;
   bit m_started = 0;

   // A pointer entering the pool at cycle N is offered no earlier than N+2
   function automatic bit exp_av();
      return m_run && (m_qp.size() > 0) && (m_qv[0] <= cyc);
   endfunction

   always @(posedge clk) begin
      bit fire;
      int p;
      if (rst) begin
         m_qp.delete();
         m_qv.delete();
         for (int i = 0; i < NUM; i++) m_map[i] = 1'b0;
         m_cnt = 0; m_ld = 0; m_run = 0; m_errd = 0; m_errr = 0;
         m_rst = 1; m_started = 1;
      end else begin
         m_rst = 0; m_errd = 0; m_errr = 0;
         if (!m_run) begin
            m_qp.push_back(m_ld);
            m_qv.push_back(cyc + 2);
            m_ld++;
            m_cnt++;
            if (m_ld == NUM) m_run = 1;
         end else begin
            fire = exp_av() && alloc_ready;
            if (free_valid) begin
               if (int'(free_ptr) >= NUM) m_errr = 1;
               else if (!m_map[free_ptr]) m_errd = 1;
               else begin
                  m_map[free_ptr] = 1'b0;
                  m_qp.push_back(int'(free_ptr));
                  m_qv.push_back(cyc + 2);
                  m_cnt++;
               end
            end
            if (fire) begin
               p = m_qp.pop_front();
               void'(m_qv.pop_front());
               m_map[p] = 1'b1;
               m_cnt--;
            end
         end
      end
      cyc++;
   end

   // ---------------- per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_started) begin
         chk("alloc_valid", alloc_valid, exp_av());
         if (exp_av()) chk("alloc_ptr", alloc_ptr, m_qp[0]);
         if (m_rst) chk("alloc_ptr_rst", alloc_ptr, 0);
         chk("free_ready", free_ready, m_run);
         chk("free_count", free_count, m_cnt);
         chk("low_wm", low_wm, (!m_run || m_cnt < LWM));
         chk("init_done", init_done, m_run);
         chk("err_double_free", err_double_free, m_errd);
         chk("err_range", err_range, m_errr);
      end
   end

   task automatic ret(input int p);
      free_valid = 1'b1;
      free_ptr   = PW'(p);
      @(negedge clk);
      free_valid = 1'b0;
   endtask

   // ---------------- directed scenarios with literal expectations
   initial begin
      rst = 1'b1; alloc_ready = 1'b0; free_valid = 1'b0; free_ptr = '0;
      repeat (3) @(negedge clk);
      chk("lit_rst_alloc_valid", alloc_valid, 0);
      chk("lit_rst_free_count", free_count, 0);
      chk("lit_rst_low_wm", low_wm, 1);

      // Init: rst low from cycle 0, init_done at cycle 12
      rst = 1'b0;
      repeat (11) @(negedge clk);
      chk("lit_init_done_c11", init_done, 0);
      @(negedge clk);
      chk("lit_init_done_c12", init_done, 1);
      chk("lit_init_count", free_count, 12);
      chk("lit_init_alloc_valid", alloc_valid, 1);
      chk("lit_init_alloc_ptr", alloc_ptr, 0);

      // Drain: pointers 0..11 on consecutive cycles
      alloc_ready = 1'b1;
      for (int i = 0; i < NUM; i++) begin
         chk("lit_drain_valid", alloc_valid, 1);
         chk("lit_drain_ptr", alloc_ptr, i);
         @(negedge clk);
      end
      alloc_ready = 1'b0;
      chk("lit_drain_empty_valid", alloc_valid, 0);
      chk("lit_drain_empty_count", free_count, 0);
      chk("lit_drain_empty_lowwm", low_wm, 1);

      // Refill: return 7 at cycle N, offered at N+2
      ret(7);
      chk("lit_refill_n1_valid", alloc_valid, 0);
      chk("lit_refill_n1_count", free_count, 1);
      @(negedge clk);
      chk("lit_refill_n2_valid", alloc_valid, 1);
      chk("lit_refill_n2_ptr", alloc_ptr, 7);

      // Errors: second return of 3 is a double free; 13 is out of range
      ret(3);
      chk("lit_ret3_count", free_count, 2);
      ret(3);
      chk("lit_dbl_pulse", err_double_free, 1);
      chk("lit_dbl_count", free_count, 2);
      @(negedge clk);
      chk("lit_dbl_pulse_end", err_double_free, 0);
      ret(13);
      chk("lit_rng_pulse", err_range, 1);
      chk("lit_rng_no_dbl", err_double_free, 0);
      chk("lit_rng_count", free_count, 2);

      // Simultaneous allocation and return at free_count=5
      ret(0); ret(1); ret(2);
      chk("lit_sim_pre_count", free_count, 5);
      alloc_ready = 1'b1; free_valid = 1'b1; free_ptr = PW'(4);
      @(negedge clk);
      alloc_ready = 1'b0; free_valid = 1'b0;
      chk("lit_sim_count", free_count, 5);
      chk("lit_sim_no_err", err_double_free, 0);
      chk("lit_sim_next_ptr", alloc_ptr, 3);

      // Reset mid-run after 6 allocations
      ret(5); ret(6);
      alloc_ready = 1'b1;
      repeat (6) @(negedge clk);
      alloc_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("lit_mid_rst_valid", alloc_valid, 0);
      chk("lit_mid_rst_ptr", alloc_ptr, 0);
      chk("lit_mid_rst_ready", free_ready, 0);
      chk("lit_mid_rst_count", free_count, 0);
      chk("lit_mid_rst_lowwm", low_wm, 1);
      chk("lit_mid_rst_done", init_done, 0);
      rst = 1'b0;
      // Returns and allocation requests during INIT must be ignored
      alloc_ready = 1'b1; free_valid = 1'b1; free_ptr = PW'(5);
      repeat (4) @(negedge clk);
      alloc_ready = 1'b0; free_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("lit_reinit_done", init_done, 1);
      chk("lit_reinit_count", free_count, 12);
      chk("lit_reinit_ptr", alloc_ptr, 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/free_ptr_pool.md
FREE_PTR_POOL -- requirements
Module: free_ptr_pool

Interface
REQ-001 The block SHALL have parameter PTR_WIDTH, default 10: pointer width in bits.
REQ-002 The block SHALL have parameter NUM_PTRS, default 2**PTR_WIDTH: pool size, legal range 2..2**PTR_WIDTH.
REQ-003 The block SHALL have parameter INIT_EN, default 1: 1 = self-load pointers 0..NUM_PTRS-1 after reset, 0 = start empty.
REQ-004 The block SHALL have parameter LOW_WM, default 4: low-watermark threshold, in pointers.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  out  1  a pointer is presented on alloc_ptr
- alloc_ready  in  1  consumer takes alloc_ptr
- alloc_ptr  out  PTR_WIDTH  pointer offered
- free_valid  in  1  pointer returned
- free_ptr  in  PTR_WIDTH  pointer being returned
- free_ready  out  1  block accepts returns
- free_count  out  PTR_WIDTH+1  pointers currently in pool
- low_wm  out  1  free_count < LOW_WM
- init_done  out  1  initialisation complete
- err_double_free  out  1  one-cycle pulse, rejected return of a pointer already free
- err_range  out  1  one-cycle pulse, rejected return with free_ptr >= NUM_PTRS

Function
REQ-007 The block SHALL implement FSM states INIT and RUN; reset enters INIT; INIT->RUN when the load counter reaches NUM_PTRS (INIT_EN=1) or after one cycle (INIT_EN=0).
REQ-008 In INIT with INIT_EN=1, the block SHALL write one pointer per cycle, ascending from 0; init_done SHALL rise exactly NUM_PTRS cycles after the first cycle with rst low.
REQ-009 During INIT, alloc_valid, free_ready and both error outputs SHALL be 0; free_valid SHALL be ignored.
REQ-010 In RUN, free_ready SHALL be 1 constantly.
REQ-011 The pool SHALL be FIFO-ordered: pointers are allocated in the order loaded or returned.
REQ-012 An allocation occurs on alloc_valid&alloc_ready; alloc_ptr SHALL be stable while alloc_valid=1 and alloc_ready=0.
REQ-013 The block SHALL sustain one allocation per cycle; alloc_valid SHALL drop only when free_count=0.
REQ-014 A pointer accepted into an empty pool at cycle N SHALL appear on alloc_ptr with alloc_valid=1 at cycle N+2.
REQ-015 The block SHALL keep an NUM_PTRS-bit allocated map: set on allocation, cleared on an accepted return; initial value 0 (INIT_EN=1) or all ones (INIT_EN=0).
REQ-016 A return whose map bit is 0 SHALL be discarded, not stored; err_double_free SHALL pulse on the next cycle; free_count SHALL be unchanged.
REQ-017 A return with free_ptr >= NUM_PTRS SHALL be discarded; err_range SHALL pulse on the next cycle; err_range SHALL take precedence, and err_double_free SHALL stay 0.
REQ-018 free_count SHALL be registered and updated the cycle after each event: +1 per accepted return, -1 per allocation, unchanged for both in the same cycle.
REQ-019 free_count SHALL never exceed NUM_PTRS or underflow; the pool SHALL never overflow, since the map guarantees at most NUM_PTRS pointers.
REQ-020 low_wm SHALL be registered from free_count, and SHALL be 1 in INIT.
REQ-021 Storage SHALL be a single inferred simple-dual-port RAM of NUM_PTRS x PTR_WIDTH, with read and write pointers wrapping at NUM_PTRS, including non-power-of-2 values.

Reset
REQ-022 With rst=1, the block SHALL hold: alloc_valid=0, alloc_ptr=0, free_ready=0, free_count=0, low_wm=1, init_done=0, err_double_free=0, err_range=0.
REQ-023 Reset asserted mid-operation SHALL discard all pool contents and map state and re-enter INIT; no pointer SHALL be presented until init_done.

Verification
REQ-024 Init: PTR_WIDTH=4, NUM_PTRS=12, rst low at cycle 0 -> init_done=1 at cycle 12; free_count=12; alloc_valid=1 with alloc_ptr=0.
REQ-025 Drain: alloc_ready=1 held for 12 cycles -> ptrs 0..11 on consecutive cycles; then alloc_valid=0, free_count=0, low_wm=1.
REQ-026 Refill: empty pool, free ptr 7 at cycle N -> alloc_ptr=7 with alloc_valid=1 at N+2; free_count=1.
REQ-027 Simultaneous: with free_count=5, alloc and return of a held ptr in the same cycle -> free_count stays 5; both accepted.
REQ-028 Errors: return ptr 3 twice -> second gives an err_double_free pulse and free_count +1 only; return ptr 13 -> err_range pulse and no count change.
REQ-029 Reset mid-run: rst for 1 cycle after 6 allocations -> all outputs at reset values; full re-init; alloc_ptr=0 after init_done.
